// File: rtl/voucher_redeem_ctrl.sv
// Voucher redemption controller: validates a scanned voucher code, rejects
// codes already redeemed among the last DEPTH accepted ones, and credits the
// voucher value into a saturating account balance.
module voucher_redeem_ctrl #(
   parameter int DEPTH = 8,
   parameter int BAL_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      voucher_id,
   input  logic             scan_done,
   output logic             busy,
   output logic             result_valid,
   output logic [1:0]       status,
   output logic [7:0]       credit,
   output logic [BAL_W-1:0] balance,
   output logic             scan_dropped
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_BAD  = 2'b01;
   localparam logic [1:0] ST_DUP  = 2'b10;
   localparam logic [1:0] ST_ZERO = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOOKUP, S_UPDATE, S_REPORT} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [15:0]       r_id;
   logic [15:0]       r_tab [DEPTH];
   logic [DEPTH-1:0]  r_vld;
   logic [IDX_W-1:0]  r_wptr;
   logic [IDX_W-1:0]  r_idx;
   logic              r_match;
   logic [1:0]        r_res_status;
   logic [7:0]        r_res_credit;
   logic              r_busy;
   logic              r_result_valid;
   logic [1:0]        r_status;
   logic [7:0]        r_credit;
   logic [BAL_W-1:0]  r_balance;
   logic              r_scan_dropped;

   logic [3:0]        w_cksum;
   logic              w_bad;
   logic              w_zero;
   logic              w_hit;
   logic              w_last;
   logic [7:0]        w_credit;

   // Balance accumulation clamps at the all-ones value instead of wrapping.
   function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a, input logic [7:0] b);
      logic [BAL_W:0] sum;
      sum = {1'b0, a} + (BAL_W+1)'(b);
      return sum[BAL_W] ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
   endfunction

   assign w_cksum  = r_id[15:12] ^ r_id[11:8] ^ r_id[7:4];
   assign w_bad    = (w_cksum != r_id[3:0]);
   assign w_zero   = (r_id[15:12] == 4'd0);
   assign w_hit    = r_vld[r_idx] && (r_tab[r_idx] == r_id);
   assign w_last   = (r_idx == IDX_W'(DEPTH-1));
   assign w_credit = {4'd0, r_id[15:12]} * 8'd10;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (scan_done) w_next = S_CHECK;
         S_CHECK:  w_next = (w_bad || w_zero) ? S_REPORT : S_LOOKUP;
         S_LOOKUP: if (w_last) w_next = (r_match || w_hit) ? S_REPORT : S_UPDATE;
         S_UPDATE: w_next = S_REPORT;
         S_REPORT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Table storage; entries only become visible through their valid bits.
   always_ff @(posedge clk) begin
      if (!reset && r_state == S_UPDATE) r_tab[r_wptr] <= r_id;
   end

   // Control, lookup scan, result staging, balance and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld          <= '0;
         r_wptr         <= '0;
         r_idx          <= '0;
         r_match        <= 1'b0;
         r_res_status   <= ST_OK;
         r_res_credit   <= 8'd0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_status       <= ST_OK;
         r_credit       <= 8'd0;
         r_balance      <= '0;
         r_scan_dropped <= 1'b0;
      end else begin
         r_busy         <= (w_next != S_IDLE);
         r_result_valid <= (r_state == S_REPORT);
         r_scan_dropped <= scan_done && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (scan_done) begin
                  r_id    <= voucher_id;
                  r_idx   <= '0;
                  r_match <= 1'b0;
               end
            end
            S_CHECK: begin
               if (w_bad) begin
                  r_res_status <= ST_BAD;
                  r_res_credit <= 8'd0;
               end else if (w_zero) begin
                  r_res_status <= ST_ZERO;
                  r_res_credit <= 8'd0;
               end
            end
            S_LOOKUP: begin
               r_idx   <= r_idx + 1'b1;
               r_match <= r_match | w_hit;
               if (w_last && (r_match || w_hit)) begin
                  r_res_status <= ST_DUP;
                  r_res_credit <= 8'd0;
               end
            end
            S_UPDATE: begin
               r_vld[r_wptr] <= 1'b1;
               r_wptr        <= r_wptr + 1'b1;
               r_res_status  <= ST_OK;
               r_res_credit  <= w_credit;
               r_balance     <= sat_add(r_balance, w_credit);
            end
            S_REPORT: begin
               r_status <= r_res_status;
               r_credit <= r_res_credit;
            end
            default: ;
         endcase
      end
   end

   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign status       = r_status;
   assign credit       = r_credit;
   assign balance      = r_balance;
   assign scan_dropped = r_scan_dropped;

endmodule

// File: tb/tb_voucher_redeem_ctrl.sv
// Scoreboard bench for voucher_redeem_ctrl with a queue-based reference model.
module tb_voucher_redeem_ctrl;
   localparam int DEPTH = 8;
   localparam int BAL_W = 16;
   localparam int BAL_MAX = (1 << BAL_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [15:0]      voucher_id = 16'd0;
   logic             scan_done = 1'b0;
   logic             busy;
   logic             result_valid;
   logic [1:0]       status;
   logic [7:0]       credit;
   logic [BAL_W-1:0] balance;
   logic             scan_dropped;

   voucher_redeem_ctrl #(.DEPTH(DEPTH), .BAL_W(BAL_W)) dut (
      .clk(clk), .reset(reset), .voucher_id(voucher_id), .scan_done(scan_done),
      .busy(busy), .result_valid(result_valid), .status(status), .credit(credit),
      .balance(balance), .scan_dropped(scan_dropped)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  st;
      logic [7:0]  cr;
      int          bal;
      int unsigned lat;
      int unsigned cap;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] hist[$];
   logic [15:0] pool[$];
   int          mbal = 0;
   int          errors = 0;
   int          checks = 0;
   int          exp_drops = 0;
   int          seen_drops = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] mk_valid(input logic [3:0] hi, input logic [7:0] mid);
      return {hi, mid, hi ^ mid[7:4] ^ mid[3:0]};
   endfunction

   // Reference: rules applied directly to the code and a FIFO of the last DEPTH accepted codes.
   task automatic model(input logic [15:0] id, output exp_t e);
      logic [3:0] cks;
      bit         seen;
      cks = id[15:12] ^ id[11:8] ^ id[7:4];
      e.cr = 8'd0;
      if (cks != id[3:0]) begin
         e.st = 2'b01; e.lat = 2;
      end else if (id[15:12] == 4'd0) begin
         e.st = 2'b11; e.lat = 2;
      end else begin
         seen = 0;
         foreach (hist[k]) if (hist[k] == id) seen = 1;
         if (seen) begin
            e.st = 2'b10; e.lat = DEPTH + 2;
         end else begin
            e.st = 2'b00; e.lat = DEPTH + 3;
            e.cr = 8'(int'(id[15:12]) * 10);
            hist.push_back(id);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            mbal = mbal + int'(e.cr);
            if (mbal > BAL_MAX) mbal = BAL_MAX;
         end
      end
      e.bal = mbal;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((sbq.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("idle_timeout", 1, 0);
         sbq.delete();
      end
   endtask

   // Issues one scan from IDLE; with track=0 the scan is not modelled (used before an abort).
   task automatic scan(input logic [15:0] id, input bit track = 1);
      exp_t e;
      wait_idle();
      voucher_id = id;
      scan_done  = 1'b1;
      if (track) model(id, e);
      @(posedge clk);
      #1;
      scan_done = 1'b0;
      e.cap = cyc;
      if (track) sbq.push_back(e);
      pool.push_back(id);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      sbq.delete();
      hist.delete();
      mbal = 0;
   endtask

   // Monitor: pops the scoreboard whenever a result is presented.
   always @(negedge clk) begin
      if (!reset) begin
         if (scan_dropped) seen_drops++;
         if (result_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("status", status, e.st);
               chk("credit", credit, e.cr);
               chk("balance", balance, e.bal);
               chk("latency", cyc - e.cap, e.lat);
            end
         end
      end
   end

   initial begin
      logic [15:0] first_id;
      logic [15:0] ninth_id;
      logic [15:0] abort_id;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      sbq.delete();
      hist.delete();
      mbal = 0;
      chk("rst_busy", busy, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_scan_dropped", scan_dropped, 0);
      chk("rst_status", status, 0);
      chk("rst_credit", credit, 0);
      chk("rst_balance", balance, 0);

      // Directed: OK, duplicate, bad checksum, zero value.
      scan(16'hABCD);
      scan(16'hABCD);
      scan(16'hABC0);
      scan(16'h0000);
      wait_idle();
      chk("balance_after_directed", balance, 100);

      // Second scan 3 cycles into an accepted one must be dropped.
      scan(mk_valid(4'h3, 8'h21));
      repeat (3) @(negedge clk);
      voucher_id = mk_valid(4'h4, 8'h55);
      scan_done  = 1'b1;
      exp_drops++;
      @(posedge clk);
      #1;
      scan_done = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      chk("drop_count", seen_drops, exp_drops);

      // Table wrap: nine distinct codes evict the first.
      do_reset(2);
      for (int i = 0; i < 9; i++) begin
         logic [15:0] v;
         v = mk_valid(4'(1 + (i % 15)), 8'(8'h10 + i));
         if (i == 0) first_id = v;
         if (i == 8) ninth_id = v;
         scan(v);
      end
      scan(first_id);
      scan(ninth_id);

      // Randomized mix of valid, corrupt and repeated codes with idle gaps.
      for (int i = 0; i < 150; i++) begin
         int          r;
         logic [15:0] v;
         r = $urandom_range(0, 3);
         if (r == 0) v = 16'($urandom);
         else if (r == 1 && pool.size() > 0) v = pool[$urandom_range(0, pool.size() - 1)];
         else v = mk_valid(4'($urandom), 8'($urandom));
         scan(v);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      chk("drop_count_random", seen_drops, exp_drops);

      // Saturation with maximum-value vouchers.
      for (int k = 0; k < 450; k++) scan(mk_valid(4'hF, 8'(k)));
      wait_idle();
      chk("balance_saturated", balance, 16'hFFFF);

      // Reset in the middle of LOOKUP aborts with no table write.
      abort_id = mk_valid(4'h5, 8'hEE);
      scan(abort_id, 0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sbq.delete();
      hist.delete();
      mbal = 0;
      chk("abort_balance", balance, 0);
      chk("abort_busy", busy, 0);
      chk("abort_result_valid", result_valid, 0);
      scan(abort_id);
      scan(mk_valid(4'hF, 8'd449));
      wait_idle();
      chk("final_balance", balance, 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
